// File: rtl/cache_consts.sv
// Shared coherence constants: message encodings and system size defaults.
package cache_consts;

  // Number of private caches addressable by a sharer bitmap.
  localparam int NUM_PORTS = 16;

  // Coherence message encoding width and forward-channel message codes.
  localparam int COH_MSG_W = 3;
  localparam logic [COH_MSG_W-1:0] FWD_GETS    = 3'd0;
  localparam logic [COH_MSG_W-1:0] FWD_GETM    = 3'd1;
  localparam logic [COH_MSG_W-1:0] FWD_PUT_ACK = 3'd2;
  localparam logic [COH_MSG_W-1:0] FWD_INV     = 3'd3;

endpackage

// File: rtl/cache_types.sv
// Shared message and identifier types for the LLC channels.
package cache_types;

  import cache_consts::*;

  localparam int CACHE_ID_W  = $clog2(NUM_PORTS);
  localparam int LINE_ADDR_W = 26;
  localparam int LINE_W      = 64;

  typedef logic [CACHE_ID_W-1:0]  cache_id_t;
  typedef logic [LINE_ADDR_W-1:0] line_addr_t;
  typedef logic [COH_MSG_W-1:0]   coh_msg_t;

  // Response to a private cache, may carry line data.
  typedef struct packed {
    coh_msg_t          coh_msg;
    line_addr_t        addr;
    logic [LINE_W-1:0] line;
    cache_id_t         req_id;
    cache_id_t         dest_id;
  } llc_rsp_out_t;

  // Forwarded request / invalidation towards a private cache.
  typedef struct packed {
    coh_msg_t   coh_msg;
    line_addr_t addr;
    cache_id_t  req_id;
    cache_id_t  dest_id;
  } llc_fwd_out_t;

  // Request to main memory (read when hwrite=0, writeback when hwrite=1).
  typedef struct packed {
    logic              hwrite;
    line_addr_t        addr;
    logic [LINE_W-1:0] line;
  } llc_mem_req_t;

endpackage

// File: rtl/llc_output_encoder_pkg.sv
// Local types of the LLC output encoder: invalidation fan-out FSM states.
package llc_output_encoder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } inv_state_t;

endpackage

// File: rtl/llc_out_fifo.sv
// Small synchronous FIFO with valid/ready output, generic over the payload type.
// ready is purely !full, so a pop in the same cycle never lets a push into a full FIFO.
module llc_out_fifo #(
  parameter type T     = logic,
  parameter int  DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_push,
  input  T     i_data,
  output logic o_ready,
  output logic o_valid,
  input  logic i_pop_ready,
  output T     o_data,
  output logic o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  T                 r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign o_ready = (r_count != CNT_W'(DEPTH));
  assign o_valid = (r_count != '0);
  assign o_empty = (r_count == '0);
  assign o_data  = r_mem[r_rd_ptr];

  // Pushes into a full FIFO are dropped here; the assertion below reports them.
  assign w_push = i_push & o_ready;
  assign w_pop  = o_valid & i_pop_ready;

  // Payload storage; no reset needed since occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers (wrap naturally, DEPTH is a power of two) and occupancy count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Producer must never push while the FIFO reports not ready.
  a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst) i_push |-> o_ready);

endmodule

// File: rtl/llc_output_encoder.sv
// LLC output encoder: buffers rsp/fwd/mem messages from the core onto the
// outbound channels and expands invalidation commands into per-sharer FWD_INV
// messages, lowest sharer index first, excluding the requester.
module llc_output_encoder
  import cache_consts::*;
  import cache_types::*;
  import llc_output_encoder_pkg::*;
#(
  parameter  int NUM_PORTS  = cache_consts::NUM_PORTS,
  parameter  int FIFO_DEPTH = 2,
  localparam int INV_CNT_W  = $clog2(NUM_PORTS + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  // core side
  input  logic                 rsp_push,
  input  llc_rsp_out_t         rsp_data,
  output logic                 rsp_ready,
  input  logic                 fwd_push,
  input  llc_fwd_out_t         fwd_data,
  output logic                 fwd_ready,
  input  logic                 mem_push,
  input  llc_mem_req_t         mem_data,
  output logic                 mem_ready,
  // invalidation fan-out command
  input  logic                 inv_start,
  input  logic [NUM_PORTS-1:0] inv_sharers,
  input  cache_id_t            inv_req_id,
  input  line_addr_t           inv_addr,
  output logic                 inv_busy,
  output logic                 inv_done,
  output logic [INV_CNT_W-1:0] inv_count,
  // outbound channels
  output logic                 llc_rsp_out_valid,
  input  logic                 llc_rsp_out_ready,
  output llc_rsp_out_t         llc_rsp_out_data,
  output logic                 llc_fwd_out_valid,
  input  logic                 llc_fwd_out_ready,
  output llc_fwd_out_t         llc_fwd_out_data,
  output logic                 llc_mem_req_valid,
  input  logic                 llc_mem_req_ready,
  output llc_mem_req_t         llc_mem_req_data,
  output logic                 idle
);

  // Index of the lowest set bit; zero when the mask is empty (unused then).
  function automatic cache_id_t lowest_set(input logic [NUM_PORTS-1:0] mask);
    cache_id_t idx;
    idx = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (mask[i]) begin
        idx = cache_id_t'(i);
      end
    end
    return idx;
  endfunction

  inv_state_t             r_state;
  inv_state_t             w_state_next;
  logic [NUM_PORTS-1:0]   r_mask;
  logic [NUM_PORTS-1:0]   w_mask_next;
  line_addr_t             r_addr;
  line_addr_t             w_addr_next;
  cache_id_t              r_req_id;
  cache_id_t              w_req_id_next;
  logic [INV_CNT_W-1:0]   r_count;
  logic [INV_CNT_W-1:0]   w_count_next;

  logic [NUM_PORTS-1:0]   w_req_onehot;
  cache_id_t              w_lsb;
  logic [NUM_PORTS-1:0]   w_lsb_onehot;
  logic                   w_fan_push;
  llc_fwd_out_t           w_fan_data;

  logic                   w_fwd_push;
  llc_fwd_out_t           w_fwd_wdata;
  logic                   w_fwd_fifo_ready;
  logic                   w_rsp_empty;
  logic                   w_fwd_empty;
  logic                   w_mem_empty;

  assign w_req_onehot = NUM_PORTS'(1) << inv_req_id;
  assign w_lsb        = lowest_set(r_mask);
  assign w_lsb_onehot = NUM_PORTS'(1) << w_lsb;

  assign w_fan_data.coh_msg = FWD_INV;
  assign w_fan_data.addr    = r_addr;
  assign w_fan_data.req_id  = r_req_id;
  assign w_fan_data.dest_id = w_lsb;

  assign inv_busy  = (r_state != IDLE);
  assign inv_done  = (r_state == DONE);
  assign inv_count = inv_done ? r_count : '0;

  // While the fan-out is active it owns the fwd FIFO write port.
  assign fwd_ready   = w_fwd_fifo_ready & ~inv_busy;
  assign w_fwd_push  = inv_busy ? w_fan_push : fwd_push;
  assign w_fwd_wdata = inv_busy ? w_fan_data : fwd_data;

  assign idle = w_rsp_empty & w_fwd_empty & w_mem_empty & (r_state == IDLE);

  // Fan-out next-state and command latching; one invalidation per non-full cycle.
  always_comb begin
    w_state_next  = r_state;
    w_mask_next   = r_mask;
    w_addr_next   = r_addr;
    w_req_id_next = r_req_id;
    w_count_next  = r_count;
    w_fan_push    = 1'b0;
    case (r_state)
      IDLE: begin
        if (inv_start) begin
          w_mask_next   = inv_sharers & ~w_req_onehot;
          w_addr_next   = inv_addr;
          w_req_id_next = inv_req_id;
          w_count_next  = '0;
          w_state_next  = (w_mask_next == '0) ? DONE : SCAN;
        end
      end
      SCAN: begin
        if (w_fwd_fifo_ready) begin
          w_fan_push  = 1'b1;
          w_mask_next = r_mask & ~w_lsb_onehot;
          if (r_count != INV_CNT_W'(NUM_PORTS)) begin
            w_count_next = r_count + INV_CNT_W'(1);
          end
          if (w_mask_next == '0) begin
            w_state_next = DONE;
          end
        end
      end
      DONE: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Fan-out state register; reset abandons any fan-out in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_mask   <= '0;
      r_addr   <= '0;
      r_req_id <= '0;
      r_count  <= '0;
    end else begin
      r_state  <= w_state_next;
      r_mask   <= w_mask_next;
      r_addr   <= w_addr_next;
      r_req_id <= w_req_id_next;
      r_count  <= w_count_next;
    end
  end

  llc_out_fifo #(.T(llc_rsp_out_t), .DEPTH(FIFO_DEPTH)) u_rsp_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (rsp_push),
    .i_data      (rsp_data),
    .o_ready     (rsp_ready),
    .o_valid     (llc_rsp_out_valid),
    .i_pop_ready (llc_rsp_out_ready),
    .o_data      (llc_rsp_out_data),
    .o_empty     (w_rsp_empty)
  );

  llc_out_fifo #(.T(llc_fwd_out_t), .DEPTH(FIFO_DEPTH)) u_fwd_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_fwd_push),
    .i_data      (w_fwd_wdata),
    .o_ready     (w_fwd_fifo_ready),
    .o_valid     (llc_fwd_out_valid),
    .i_pop_ready (llc_fwd_out_ready),
    .o_data      (llc_fwd_out_data),
    .o_empty     (w_fwd_empty)
  );

  llc_out_fifo #(.T(llc_mem_req_t), .DEPTH(FIFO_DEPTH)) u_mem_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (mem_push),
    .i_data      (mem_data),
    .o_ready     (mem_ready),
    .o_valid     (llc_mem_req_valid),
    .i_pop_ready (llc_mem_req_ready),
    .o_data      (llc_mem_req_data),
    .o_empty     (w_mem_empty)
  );

  // The core may only push forwards while the encoder advertises fwd_ready.
  a_fwd_push_when_ready: assert property (@(posedge clk) disable iff (!rst) fwd_push |-> fwd_ready);

endmodule

// File: tb/tb_llc_output_encoder.sv
// Self-checking bench for llc_output_encoder: scoreboard queues per channel.
`timescale 1ns/1ps
module tb_llc_output_encoder;
  import cache_consts::*;
  import cache_types::*;

  localparam int NP    = 16;
  localparam int DEPTH = 2;
  localparam int CW    = $clog2(NP + 1);

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rsp_push = 1'b0, fwd_push = 1'b0, mem_push = 1'b0;
  llc_rsp_out_t rsp_data = '0;
  llc_fwd_out_t fwd_data = '0;
  llc_mem_req_t mem_data = '0;
  logic rsp_ready, fwd_ready, mem_ready;
  logic inv_start = 1'b0;
  logic [NP-1:0] inv_sharers = '0;
  cache_id_t inv_req_id = '0;
  line_addr_t inv_addr = '0;
  logic inv_busy, inv_done;
  logic [CW-1:0] inv_count;
  logic llc_rsp_out_valid, llc_fwd_out_valid, llc_mem_req_valid;
  logic llc_rsp_out_ready = 1'b0, llc_fwd_out_ready = 1'b0, llc_mem_req_ready = 1'b0;
  llc_rsp_out_t llc_rsp_out_data;
  llc_fwd_out_t llc_fwd_out_data;
  llc_mem_req_t llc_mem_req_data;
  logic idle;

  int tests_run = 0;
  int tests_failed = 0;
  llc_rsp_out_t rsp_q[$];
  llc_fwd_out_t fwd_q[$];
  llc_mem_req_t mem_q[$];

  always #5 clk = ~clk;

  llc_output_encoder #(.NUM_PORTS(NP), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .rsp_push(rsp_push), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
    .fwd_push(fwd_push), .fwd_data(fwd_data), .fwd_ready(fwd_ready),
    .mem_push(mem_push), .mem_data(mem_data), .mem_ready(mem_ready),
    .inv_start(inv_start), .inv_sharers(inv_sharers), .inv_req_id(inv_req_id),
    .inv_addr(inv_addr), .inv_busy(inv_busy), .inv_done(inv_done), .inv_count(inv_count),
    .llc_rsp_out_valid(llc_rsp_out_valid), .llc_rsp_out_ready(llc_rsp_out_ready),
    .llc_rsp_out_data(llc_rsp_out_data),
    .llc_fwd_out_valid(llc_fwd_out_valid), .llc_fwd_out_ready(llc_fwd_out_ready),
    .llc_fwd_out_data(llc_fwd_out_data),
    .llc_mem_req_valid(llc_mem_req_valid), .llc_mem_req_ready(llc_mem_req_ready),
    .llc_mem_req_data(llc_mem_req_data),
    .idle(idle)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic llc_rsp_out_t mk_rsp();
    llc_rsp_out_t r;
    r.coh_msg = coh_msg_t'($urandom_range(0, 7));
    r.addr    = line_addr_t'($urandom);
    r.line    = {$urandom, $urandom};
    r.req_id  = cache_id_t'($urandom_range(0, NP - 1));
    r.dest_id = cache_id_t'($urandom_range(0, NP - 1));
    return r;
  endfunction

  function automatic llc_fwd_out_t mk_fwd();
    llc_fwd_out_t f;
    f.coh_msg = coh_msg_t'($urandom_range(0, 2));
    f.addr    = line_addr_t'($urandom);
    f.req_id  = cache_id_t'($urandom_range(0, NP - 1));
    f.dest_id = cache_id_t'($urandom_range(0, NP - 1));
    return f;
  endfunction

  function automatic llc_mem_req_t mk_mem();
    llc_mem_req_t m;
    m.hwrite = 1'($urandom_range(0, 1));
    m.addr   = line_addr_t'($urandom);
    m.line   = {$urandom, $urandom};
    return m;
  endfunction

  // Output side of the scoreboard: a handshake seen at the falling edge completes
  // at the next rising edge, so pop the expected message and compare it now.
  task automatic monitor();
    llc_rsp_out_t er;
    llc_fwd_out_t ef;
    llc_mem_req_t em;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (llc_rsp_out_valid && llc_rsp_out_ready) begin
          tests_run++;
          if (rsp_q.size() == 0) begin
            tests_failed++;
            $display("FAIL rsp_unexpected got=%h required=none", llc_rsp_out_data);
          end else begin
            er = rsp_q.pop_front();
            if (llc_rsp_out_data !== er) begin
              tests_failed++;
              $display("FAIL rsp_data got=%h required=%h", llc_rsp_out_data, er);
            end
          end
        end
        if (llc_fwd_out_valid && llc_fwd_out_ready) begin
          tests_run++;
          if (fwd_q.size() == 0) begin
            tests_failed++;
            $display("FAIL fwd_unexpected got=%h required=none", llc_fwd_out_data);
          end else begin
            ef = fwd_q.pop_front();
            if (llc_fwd_out_data !== ef) begin
              tests_failed++;
              $display("FAIL fwd_data got=%h (dest %0d) required=%h (dest %0d)",
                       llc_fwd_out_data, llc_fwd_out_data.dest_id, ef, ef.dest_id);
            end
          end
        end
        if (llc_mem_req_valid && llc_mem_req_ready) begin
          tests_run++;
          if (mem_q.size() == 0) begin
            tests_failed++;
            $display("FAIL mem_unexpected got=%h required=none", llc_mem_req_data);
          end else begin
            em = mem_q.pop_front();
            if (llc_mem_req_data !== em) begin
              tests_failed++;
              $display("FAIL mem_data got=%h required=%h", llc_mem_req_data, em);
            end
          end
        end
      end
    end
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    llc_rsp_out_ready = 1'b1;
    llc_fwd_out_ready = 1'b1;
    llc_mem_req_ready = 1'b1;
    while ((rsp_q.size() != 0 || fwd_q.size() != 0 || mem_q.size() != 0 || idle !== 1'b1) && n < 200) begin
      tick();
      n++;
    end
    tests_run++;
    if (n >= 200) begin
      tests_failed++;
      $display("FAIL %s_drain got rsp_q=%0d fwd_q=%0d mem_q=%0d idle=%b required empty and idle=1",
               name, rsp_q.size(), fwd_q.size(), mem_q.size(), idle);
    end
    $display("[TB] %s: drained after %0d cycles", name, n);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if ({rsp_ready, fwd_ready, mem_ready} !== 3'b111) begin
      tests_failed++;
      $display("FAIL reset_ready got=%b required=111", {rsp_ready, fwd_ready, mem_ready});
    end
    tests_run++;
    if ({llc_rsp_out_valid, llc_fwd_out_valid, llc_mem_req_valid} !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_valid got=%b required=000",
               {llc_rsp_out_valid, llc_fwd_out_valid, llc_mem_req_valid});
    end
    tests_run++;
    if ({inv_busy, inv_done, inv_count, idle} !== {1'b0, 1'b0, CW'(0), 1'b1}) begin
      tests_failed++;
      $display("FAIL reset_inv got busy=%b done=%b count=%0d idle=%b required 0 0 0 1",
               inv_busy, inv_done, inv_count, idle);
    end
    rst = 1'b1;
    tick();
    $display("[TB] reset: checked");
  endtask

  task automatic test_rsp_backpressure();
    llc_rsp_out_t a, b, c;
    int n;
    a = mk_rsp(); b = mk_rsp(); c = mk_rsp();
    llc_rsp_out_ready = 1'b0;
    rsp_push = 1'b1; rsp_data = a; rsp_q.push_back(a);
    tick();
    tests_run++;
    if (llc_rsp_out_valid !== 1'b1 || llc_rsp_out_data !== a || rsp_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL rsp_first_latency got valid=%b data=%h ready=%b required 1 %h 1",
               llc_rsp_out_valid, llc_rsp_out_data, rsp_ready, a);
    end
    rsp_data = b; rsp_q.push_back(b);
    tick();
    rsp_push = 1'b0;
    repeat (3) tick();
    tests_run++;
    if (rsp_ready !== 1'b0 || llc_rsp_out_data !== a) begin
      tests_failed++;
      $display("FAIL rsp_full_hold got ready=%b head=%h required 0 %h", rsp_ready, llc_rsp_out_data, a);
    end
    llc_rsp_out_ready = 1'b1;
    n = 0;
    while (rsp_ready !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    tests_run++;
    if (rsp_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL rsp_ready_reopen got=%b required=1", rsp_ready);
    end else begin
      rsp_push = 1'b1; rsp_data = c; rsp_q.push_back(c);
      tick();
      rsp_push = 1'b0;
    end
    wait_drain("rsp_backpressure");
  endtask

  // Fan-out with the fwd channel always ready: checks cycle-exact inv_done and valids.
  task automatic test_fanout(input logic [NP-1:0] sharers, input cache_id_t req, input string name);
    int k;
    line_addr_t addr;
    logic exp_done, exp_valid;
    k = 0;
    addr = line_addr_t'($urandom);
    for (int i = 0; i < NP; i++) begin
      if (sharers[i] && i != int'(req)) begin
        fwd_q.push_back('{coh_msg: FWD_INV, addr: addr, req_id: req, dest_id: cache_id_t'(i)});
        k++;
      end
    end
    llc_fwd_out_ready = 1'b1;
    inv_start = 1'b1; inv_sharers = sharers; inv_req_id = req; inv_addr = addr;
    tick();
    inv_start = 1'b0;
    inv_sharers = ~sharers;
    tests_run++;
    if ({inv_busy, fwd_ready} !== 2'b10) begin
      tests_failed++;
      $display("FAIL %s_busy got busy=%b fwd_ready=%b required 1 0", name, inv_busy, fwd_ready);
    end
    for (int c = 1; c <= k + 1; c++) begin
      exp_done  = (c == k + 1);
      exp_valid = (c >= 2);
      tests_run++;
      if ({inv_done, llc_fwd_out_valid} !== {exp_done, exp_valid}) begin
        tests_failed++;
        $display("FAIL %s_cycle%0d got done=%b valid=%b required %b %b",
                 name, c, inv_done, llc_fwd_out_valid, exp_done, exp_valid);
      end
      if (c == k + 1) begin
        tests_run++;
        if (inv_count !== CW'(k)) begin
          tests_failed++;
          $display("FAIL %s_count got=%0d required=%0d", name, inv_count, k);
        end
      end else begin
        tick();
      end
    end
    tick();
    tests_run++;
    if ({inv_done, inv_busy} !== 2'b00) begin
      tests_failed++;
      $display("FAIL %s_after_done got done=%b busy=%b required 0 0", name, inv_done, inv_busy);
    end
    wait_drain(name);
  endtask

  task automatic test_fanout_backpressure();
    logic [3:0] pat;
    line_addr_t addr;
    int n, done_seen;
    logic [CW-1:0] cnt;
    logic valid_at_done;
    pat = 4'b1001;
    addr = line_addr_t'($urandom);
    for (int i = 0; i < NP; i++) begin
      if (i == 0 || i == 5 || i == 10 || i == 15) begin
        fwd_q.push_back('{coh_msg: FWD_INV, addr: addr, req_id: cache_id_t'(1), dest_id: cache_id_t'(i)});
      end
    end
    inv_start = 1'b1; inv_sharers = 16'h8421; inv_req_id = cache_id_t'(1); inv_addr = addr;
    llc_fwd_out_ready = pat[0];
    tick();
    inv_start = 1'b0;
    n = 0; done_seen = 0; cnt = '0; valid_at_done = 1'b0;
    while (n < 60 && inv_busy === 1'b1) begin
      n++;
      llc_fwd_out_ready = pat[n % 4];
      if (inv_done === 1'b1) begin
        done_seen++;
        cnt = inv_count;
        valid_at_done = llc_fwd_out_valid;
      end
      tick();
    end
    tests_run++;
    if (done_seen != 1 || cnt !== CW'(4) || valid_at_done !== 1'b1) begin
      tests_failed++;
      $display("FAIL fanout_bp got done_pulses=%0d count=%0d valid_at_done=%b required 1 4 1",
               done_seen, cnt, valid_at_done);
    end
    wait_drain("fanout_backpressure");
  endtask

  task automatic test_reset_mid_scan();
    llc_fwd_out_ready = 1'b0;
    inv_start = 1'b1; inv_sharers = 16'h001F; inv_req_id = cache_id_t'(9);
    inv_addr = line_addr_t'($urandom);
    tick();
    inv_start = 1'b0;
    repeat (3) tick();
    tests_run++;
    if ({inv_busy, llc_fwd_out_valid, fwd_ready} !== 3'b110) begin
      tests_failed++;
      $display("FAIL midscan_pre got busy=%b valid=%b fwd_ready=%b required 1 1 0",
               inv_busy, llc_fwd_out_valid, fwd_ready);
    end
    rst = 1'b0;
    #1;
    tests_run++;
    if ({llc_rsp_out_valid, llc_fwd_out_valid, llc_mem_req_valid, inv_busy, inv_done, idle} !== 6'b000001) begin
      tests_failed++;
      $display("FAIL midscan_reset got valids=%b busy=%b done=%b idle=%b required 000 0 0 1",
               {llc_rsp_out_valid, llc_fwd_out_valid, llc_mem_req_valid}, inv_busy, inv_done, idle);
    end
    tick();
    rst = 1'b1;
    llc_fwd_out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      tests_run++;
      if ({inv_done, llc_fwd_out_valid, inv_busy, idle} !== 4'b0001) begin
        tests_failed++;
        $display("FAIL midscan_after%0d got done=%b valid=%b busy=%b idle=%b required 0 0 0 1",
                 c, inv_done, llc_fwd_out_valid, inv_busy, idle);
      end
    end
    $display("[TB] reset_mid_scan: checked");
  endtask

  task automatic test_mem_simul();
    llc_mem_req_t m0, m1, m2;
    m0 = mk_mem(); m1 = mk_mem(); m2 = mk_mem();
    llc_mem_req_ready = 1'b0;
    mem_push = 1'b1; mem_data = m0; mem_q.push_back(m0);
    tick();
    llc_mem_req_ready = 1'b1; mem_data = m1; mem_q.push_back(m1);
    tick();
    mem_push = 1'b0; llc_mem_req_ready = 1'b0;
    tests_run++;
    if (mem_ready !== 1'b1 || llc_mem_req_valid !== 1'b1 || llc_mem_req_data !== m1) begin
      tests_failed++;
      $display("FAIL mem_simul_count1 got ready=%b valid=%b head=%h required 1 1 %h",
               mem_ready, llc_mem_req_valid, llc_mem_req_data, m1);
    end
    mem_push = 1'b1; mem_data = m2; mem_q.push_back(m2);
    tick();
    mem_push = 1'b0;
    tests_run++;
    if (mem_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL mem_simul_full got ready=%b required=0", mem_ready);
    end
    wait_drain("mem_simul");
  endtask

  task automatic test_back_to_back();
    llc_rsp_out_t r;
    llc_fwd_out_t f;
    llc_mem_req_t m;
    for (int c = 0; c < 60; c++) begin
      llc_rsp_out_ready = 1'($urandom_range(0, 3) != 0);
      llc_fwd_out_ready = 1'($urandom_range(0, 1));
      llc_mem_req_ready = 1'($urandom_range(0, 3) != 0);
      rsp_push = rsp_ready && ($urandom_range(0, 3) != 0);
      fwd_push = fwd_ready && ($urandom_range(0, 1) != 0);
      mem_push = mem_ready && ($urandom_range(0, 2) != 0);
      if (rsp_push) begin r = mk_rsp(); rsp_data = r; rsp_q.push_back(r); end
      if (fwd_push) begin f = mk_fwd(); fwd_data = f; fwd_q.push_back(f); end
      if (mem_push) begin m = mk_mem(); mem_data = m; mem_q.push_back(m); end
      tick();
    end
    rsp_push = 1'b0; fwd_push = 1'b0; mem_push = 1'b0;
    wait_drain("back_to_back");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_rsp_backpressure();
    test_fanout(16'b0000_0000_0010_1101, cache_id_t'(2), "fanout_basic");
    test_fanout(16'h0004, cache_id_t'(2), "fanout_req_only");
    test_fanout(16'hFFFF, cache_id_t'(15), "fanout_wide");
    test_fanout_backpressure();
    test_reset_mid_scan();
    test_mem_simul();
    test_back_to_back();
    repeat (2) tick();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
